mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DM_WORDS, default 1024, data-memory depth in 32-bit words (power of two).
REQ-002 Parameter DM_AW, default 10, word-address width, equals log2(DM_WORDS).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 clr  in  1  reset, synchronous and active-low.
REQ-005 i_valid  in  1  EX-stage slot holds a real instruction.
REQ-006 i_busC  in  32  ALU result: writeback value, or byte address for load/store.
REQ-007 i_busB  in  32  store data, forwarded rt.
REQ-008 i_rd  in  5  destination register.
REQ-009 i_GPRWr / i_DMWr / i_MTR  in  1 each  register write, memory write, memory-to-register.
REQ-010 o_GPRWr  out  1  GPR write enable.
REQ-011 o_rw  out  5  GPR write address.
REQ-012 o_busW  out  32  GPR write data.
REQ-013 o_fwd_mem_vld / o_fwd_mem_rd[4:0] / o_fwd_mem_data[32]  out  MEM-stage bypass.
REQ-014 o_fwd_wb_vld / o_fwd_wb_rd[4:0] / o_fwd_wb_data[32]  out  WB-stage bypass.

Function
REQ-015 The block SHALL hold an EX/MEM register (valid, busC, busB, rd, GPRWr, DMWr, MTR), loaded from the i_* inputs every edge.
REQ-016 The block SHALL hold a MEM/WB register (valid, rd, GPRWr, result), loaded from EX/MEM every edge.
REQ-017 Word address SHALL be EX/MEM busC[DM_AW+1:2]; bits [1:0] are ignored; higher bits are ignored, so addresses wrap modulo DM_WORDS.
REQ-018 Memory read SHALL be combinational from the EX/MEM address during the MEM cycle.
REQ-019 Memory write SHALL occur at the edge ending the MEM cycle, only when EX/MEM valid=1 and DMWr=1.
REQ-020 MEM/WB result SHALL be the memory read data when MTR=1, else EX/MEM busC.
REQ-021 Latency: an instruction sampled at edge N SHALL write memory at edge N+1 and drive o_busW/o_rw/o_GPRWr for the cycle between edges N+1 and N+2.
REQ-022 o_GPRWr SHALL equal MEM/WB valid AND GPRWr AND (rd != 0); writes to r0 are suppressed.
REQ-023 A load in MEM immediately after a store to the same word SHALL read the stored data, because the store completes one edge earlier.
REQ-024 With i_valid=0 the slot SHALL propagate as a bubble: no memory write, o_GPRWr=0.
REQ-025 There is no stall input; the pipeline advances every cycle.

Reset
REQ-026 When clr=0 at an edge, both pipeline registers SHALL clear to all-zero (valid=0), giving o_GPRWr=0, o_rw=0, o_busW=0, and all o_fwd_* = 0.
REQ-027 A store sitting in MEM at a reset edge SHALL NOT write memory; clr takes priority.
REQ-028 Data-memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_WB_BYPASS_EN defined: o_fwd_mem_* SHALL present EX/MEM rd/busC, with vld = valid AND GPRWr AND NOT MTR AND rd!=0; o_fwd_wb_* SHALL mirror o_GPRWr/o_rw/o_busW.
REQ-030 Macro undefined: all o_fwd_* ports SHALL remain present and be tied to 0; no bypass logic is synthesised.

Structure
REQ-031 Shared package mips_pkg SHALL hold DM_WORDS/DM_AW defaults, the 5-bit register-index width, and the MEM control-bundle typedef {GPRWr, DMWr, MTR}.
REQ-032 Data memory SHALL be a sub-module dm_4k (async read, sync write, DM_WORDS x 32); pipeline registers and the writeback mux stay in mem_wb_pipe.

Verification
REQ-033 ALU op: i_valid=1, i_busC=0x1234, i_rd=8, i_GPRWr=1 at edge N -> o_GPRWr=1, o_rw=8, o_busW=0x1234 after edge N+1.
REQ-034 Store then load: store busC=0x40, busB=0xDEADBEEF; next cycle load busC=0x40, rd=9, MTR=1 -> o_busW=0xDEADBEEF, o_rw=9.
REQ-035 Wrap: store to 0x1004 with DM_WORDS=1024, then load from 0x0004 -> loaded data equals the stored data.
REQ-036 r0: i_rd=0, i_GPRWr=1, busC=0x5 -> o_GPRWr=0; with bypass enabled, o_fwd_mem_vld=0.
REQ-037 Reset mid-store: store 0x55 to 0x80 in MEM while clr=0 -> outputs zero, a later load of 0x80 returns the prior contents.
REQ-038 Bypass build: ALU result 0xA5 to rd=3 -> o_fwd_mem_vld=1 with data 0xA5 one cycle, then o_fwd_wb_vld=1 with data 0xA5 the next; for a load, o_fwd_mem_vld=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: data-memory geometry defaults, register-index width
// and the control bundle carried into the MEM stage.
package mips_pkg;

    localparam int DM_WORDS_DEF = 1024;
    localparam int DM_AW_DEF    = 10;
    localparam int REG_AW       = 5;

    typedef struct packed {
        logic GPRWr;
        logic DMWr;
        logic MTR;
    } memCtl_t;

endpackage

// File: rtl/dm_4k.sv
// Data memory: DM_WORDS x 32, combinational read, write on the rising edge.
// Latency: read 0 cycles, write lands at the next edge. No backpressure; contents are never reset.
module dm_4k #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DM_AW-1:0] addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM and WB stages: EX/MEM and MEM/WB registers, data memory, writeback mux; MEM_WB_BYPASS_EN adds forwarding.
// Latency: sampled at edge N, memory written at N+1, writeback presented between N+1 and N+2.
// No backpressure: the pipeline advances every cycle; clr (sync, active-low) flushes both stages.
module mem_wb_pipe
    import mips_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int DM_AW    = DM_AW_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_valid,
    input  logic [31:0]       i_busC,
    input  logic [31:0]       i_busB,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_GPRWr,
    input  logic              i_DMWr,
    input  logic              i_MTR,
    output logic              o_GPRWr,
    output logic [REG_AW-1:0] o_rw,
    output logic [31:0]       o_busW,
    output logic              o_fwd_mem_vld,
    output logic [REG_AW-1:0] o_fwd_mem_rd,
    output logic [31:0]       o_fwd_mem_data,
    output logic              o_fwd_wb_vld,
    output logic [REG_AW-1:0] o_fwd_wb_rd,
    output logic [31:0]       o_fwd_wb_data
);

    // EX/MEM register
    logic              exValid;
    logic [31:0]       exBusC;
    logic [31:0]       exBusB;
    logic [REG_AW-1:0] exRd;
    memCtl_t           exCtl;

    // MEM/WB register
    logic              wbValid;
    logic [REG_AW-1:0] wbRd;
    logic              wbGPRWr;
    logic [31:0]       wbResult;

    logic [DM_AW-1:0]  dmAddr;
    logic [31:0]       dmRdata;
    logic              dmWe;
    logic              unusedAddrBits;

    // Byte offset and bits above the memory depth are dropped, so addresses wrap.
    assign dmAddr         = exBusC[DM_AW+1:2];
    assign unusedAddrBits = ^{exBusC[31:DM_AW+2], exBusC[1:0]};

    // A store caught by a reset edge must not land in memory.
    assign dmWe = clr & exValid & exCtl.DMWr;

    dm_4k #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm (
        .clk  (clk),
        .we   (dmWe),
        .addr (dmAddr),
        .wd   (exBusB),
        .rd   (dmRdata)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            exValid  <= 1'b0;
            exBusC   <= '0;
            exBusB   <= '0;
            exRd     <= '0;
            exCtl    <= '0;
            wbValid  <= 1'b0;
            wbRd     <= '0;
            wbGPRWr  <= 1'b0;
            wbResult <= '0;
        end else begin
            exValid  <= i_valid;
            exBusC   <= i_busC;
            exBusB   <= i_busB;
            exRd     <= i_rd;
            exCtl    <= '{GPRWr: i_GPRWr, DMWr: i_DMWr, MTR: i_MTR};
            wbValid  <= exValid;
            wbRd     <= exRd;
            wbGPRWr  <= exCtl.GPRWr;
            wbResult <= exCtl.MTR ? dmRdata : exBusC;
        end
    end

    assign o_GPRWr = wbValid & wbGPRWr & (wbRd != '0);
    assign o_rw    = wbRd;
    assign o_busW  = wbResult;

`ifdef MEM_WB_BYPASS_EN
    // A load's value is not known until the end of MEM, so it is never forwarded from here.
    assign o_fwd_mem_vld  = exValid & exCtl.GPRWr & ~exCtl.MTR & (exRd != '0);
    assign o_fwd_mem_rd   = exRd;
    assign o_fwd_mem_data = exBusC;
    assign o_fwd_wb_vld   = o_GPRWr;
    assign o_fwd_wb_rd    = o_rw;
    assign o_fwd_wb_data  = o_busW;
`else
    assign o_fwd_mem_vld  = 1'b0;
    assign o_fwd_mem_rd   = '0;
    assign o_fwd_mem_data = '0;
    assign o_fwd_wb_vld   = 1'b0;
    assign o_fwd_wb_rd    = '0;
    assign o_fwd_wb_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed table bench for mem_wb_pipe; bypass expectations follow MEM_WB_BYPASS_EN.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        clr;
    logic        i_valid;
    logic [31:0] i_busC;
    logic [31:0] i_busB;
    logic [4:0]  i_rd;
    logic        i_GPRWr, i_DMWr, i_MTR;
    logic        o_GPRWr;
    logic [4:0]  o_rw;
    logic [31:0] o_busW;
    logic        o_fwd_mem_vld, o_fwd_wb_vld;
    logic [4:0]  o_fwd_mem_rd, o_fwd_wb_rd;
    logic [31:0] o_fwd_mem_data, o_fwd_wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe dut (
        .clk            (clk),
        .clr            (clr),
        .i_valid        (i_valid),
        .i_busC         (i_busC),
        .i_busB         (i_busB),
        .i_rd           (i_rd),
        .i_GPRWr        (i_GPRWr),
        .i_DMWr         (i_DMWr),
        .i_MTR          (i_MTR),
        .o_GPRWr        (o_GPRWr),
        .o_rw           (o_rw),
        .o_busW         (o_busW),
        .o_fwd_mem_vld  (o_fwd_mem_vld),
        .o_fwd_mem_rd   (o_fwd_mem_rd),
        .o_fwd_mem_data (o_fwd_mem_data),
        .o_fwd_wb_vld   (o_fwd_wb_vld),
        .o_fwd_wb_rd    (o_fwd_wb_rd),
        .o_fwd_wb_data  (o_fwd_wb_data)
    );

    typedef struct {
        logic        valid;
        logic [31:0] busC;
        logic [31:0] busB;
        logic [4:0]  rd;
        logic        gprWr;
        logic        dmWr;
        logic        mtr;
        logic        expWr;
        logic [4:0]  expRw;
        logic [31:0] expBusW;
        logic        expFwd;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

`ifdef MEM_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] c, input logic [31:0] b,
                         input logic [4:0] r, input logic g, input logic d, input logic m);
        i_valid = v; i_busC = c; i_busB = b; i_rd = r;
        i_GPRWr = g; i_DMWr = d; i_MTR = m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkWb(input string tag, input logic wr, input logic [4:0] rw, input logic [31:0] bw);
        chk({tag, " GPRWr"}, 32'(o_GPRWr), 32'(wr));
        chk({tag, " rw"}, 32'(o_rw), 32'(rw));
        chk({tag, " busW"}, o_busW, bw);
        chk({tag, " fwd_wb_vld"}, 32'(o_fwd_wb_vld), BYP ? 32'(wr) : 32'd0);
        chk({tag, " fwd_wb_rd"}, 32'(o_fwd_wb_rd), BYP ? 32'(rw) : 32'd0);
        chk({tag, " fwd_wb_data"}, o_fwd_wb_data, BYP ? bw : 32'd0);
    endtask

    task automatic chkFwdMem(input string tag, input logic v, input logic [4:0] r, input logic [31:0] d);
        chk({tag, " fwd_mem_vld"}, 32'(o_fwd_mem_vld), BYP ? 32'(v) : 32'd0);
        chk({tag, " fwd_mem_rd"}, 32'(o_fwd_mem_rd), BYP ? 32'(r) : 32'd0);
        chk({tag, " fwd_mem_data"}, o_fwd_mem_data, BYP ? d : 32'd0);
    endtask

    initial begin
        //            valid  busC          busB          rd     GPRWr DMWr  MTR    expWr expRw  expBusW       expFwd
        tbl[0]  = '{1'b1, 32'h0000_1234, 32'h0,         5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  32'h0000_1234, 1'b1};
        tbl[1]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0040, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0040, 32'h0,         5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_1004, 32'hCAFE_F00D, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_1004, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0004, 32'h0,         5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hCAFE_F00D, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0005, 32'h0,         5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0005, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0040, 32'h0000_0BAD, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0040, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0040, 32'h0,         5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_00A5, 32'h0,         5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_00A5, 1'b1};
        tbl[9]  = '{1'b1, 32'h0000_0043, 32'h0,         5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0077, 32'h0,         5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_0077, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0};

        // Reset with a live-looking instruction on the inputs: both stages must still clear.
        clr = 1'b0;
        drive(1'b1, 32'h0000_1234, 32'h1111_1111, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chkWb("reset", 1'b0, 5'd0, 32'h0);
        chk("reset fwd_mem_vld", 32'(o_fwd_mem_vld), 32'd0);
        chk("reset fwd_mem_rd", 32'(o_fwd_mem_rd), 32'd0);
        chk("reset fwd_mem_data", o_fwd_mem_data, 32'd0);
        clr = 1'b1;

        // Streamed table: after the edge sampling row i, MEM holds row i and WB holds row i-1.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV)
                drive(tbl[i].valid, tbl[i].busC, tbl[i].busB, tbl[i].rd,
                      tbl[i].gprWr, tbl[i].dmWr, tbl[i].mtr);
            else
                drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (i < NV)
                chkFwdMem($sformatf("row%0d", i), tbl[i].expFwd, tbl[i].rd, tbl[i].busC);
            if (i > 0)
                chkWb($sformatf("row%0d", i - 1), tbl[i-1].expWr, tbl[i-1].expRw, tbl[i-1].expBusW);
        end

        // Reset while a store is in MEM: the store is dropped, earlier memory contents survive.
        drive(1'b1, 32'h0000_0080, 32'h1122_3344, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0000_0080, 32'h0000_0055, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        clr = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chkWb("midreset", 1'b0, 5'd0, 32'h0);
        chkFwdMem("midreset", 1'b0, 5'd0, 32'h0);
        chk("midreset fwd_mem_vld raw", 32'(o_fwd_mem_vld), 32'd0);
        clr = 1'b1;
        drive(1'b1, 32'h0000_0080, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        step();
        chkFwdMem("reload", 1'b0, 5'd6, 32'h0000_0080);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chkWb("reload", 1'b1, 5'd6, 32'h1122_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
